// File: rtl/loeffler_dct_engine.sv
`default_nettype none
// ============================================================================
//  Module      : loeffler_dct_engine
//  Description : Handshaked 8-point forward/inverse DCT, one coefficient per
//                cycle from a constant ROM, rounded and saturated to OUT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module loeffler_dct_engine #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*IN_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 out_mode,
    output logic                 busy
);

    localparam int PROD_W = IN_W + COEF_W;
    localparam int SUM_W  = PROD_W + 3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic signed [SUM_W-1:0] c_half    = SUM_W'(64'd1 << (FRAC - 1));
    localparam logic signed [SUM_W-1:0] c_sat_max = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] c_sat_min = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Cosine magnitudes are held at 2^30 scale and rounded down to FRAC bits,
    // so the ROM follows FRAC without a per-parameter table.
    function automatic integer coef_val(input integer k, input integer n);
        integer idx;
        integer mag;
        integer neg;
        idx = ((2 * n + 1) * k) % 32;
        neg = 0;
        if (idx > 16) idx = 32 - idx;
        if (idx > 8) begin
            idx = 16 - idx;
            neg = 1;
        end
        case (idx)
            0:       mag = 536870912;
            1:       mag = 526555088;
            2:       mag = 496004047;
            3:       mag = 446391849;
            4:       mag = 379625062;
            5:       mag = 298269498;
            6:       mag = 205451603;
            7:       mag = 104738319;
            default: mag = 0;
        endcase
        if (k == 0) mag = 379625062;
        mag = (mag + (1 << (29 - FRAC))) >>> (30 - FRAC);
        return (neg != 0) ? -mag : mag;
    endfunction

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [2:0]                r_k;
    logic [8*IN_W-1:0]         r_din;
    logic                      r_mode;
    logic [8*OUT_W-1:0]        r_dout;
    logic                      w_accept;

    logic signed [COEF_W-1:0]  w_rom  [64];
    logic signed [COEF_W-1:0]  w_coef [8];
    logic signed [PROD_W-1:0]  w_prod [8];
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_rnd;
    logic signed [SUM_W-1:0]   w_shift;
    logic signed [OUT_W-1:0]   w_sat;

    generate
        for (genvar gk = 0; gk < 8; gk++) begin : g_rom_k
            for (genvar gn = 0; gn < 8; gn++) begin : g_rom_n
                assign w_rom[gk*8+gn] = COEF_W'(coef_val(gk, gn));
            end
        end
    endgenerate

    // Inverse mode walks the ROM column-wise (transposed matrix).
    always_comb begin
        w_sum = '0;
        for (int n = 0; n < 8; n++) begin
            w_coef[n] = r_mode ? w_rom[{3'(n), r_k}] : w_rom[{r_k, 3'(n)}];
            w_prod[n] = PROD_W'($signed(r_din[n*IN_W +: IN_W])) * PROD_W'(w_coef[n]);
            w_sum     = w_sum + SUM_W'(w_prod[n]);
        end
        w_rnd   = w_sum + c_half;
        w_shift = w_rnd >>> FRAC;
        if (w_shift > c_sat_max)
            w_sat = c_sat_max[OUT_W-1:0];
        else if (w_shift < c_sat_min)
            w_sat = c_sat_min[OUT_W-1:0];
        else
            w_sat = w_shift[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid)
                    w_state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (r_k == 3'd7)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_state_next = in_valid ? S_COMPUTE : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:    in_ready = 1'b1;
            S_COMPUTE: busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k    <= '0;
            r_din  <= '0;
            r_mode <= 1'b0;
            r_dout <= '0;
        end else if (w_accept) begin
            r_din  <= in_data;
            r_mode <= in_mode;
            r_k    <= '0;
        end else if (busy) begin
            r_dout[int'(r_k)*OUT_W +: OUT_W] <= w_sat;
            r_k                              <= r_k + 3'd1;
        end
    end

    assign out_data = r_dout;
    assign out_mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_loeffler_dct_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loeffler_dct_engine
//  Description : Table, directed and random checks of the DCT engine against
//                a real-arithmetic reference, at OUT_W=16 and OUT_W=12.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loeffler_dct_engine;

    localparam int IN_W = 12;
    localparam int FRAC = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_mode;
    logic [8*IN_W-1:0] in_data;
    logic              out_ready;
    logic              in_ready_w, out_valid_w, out_mode_w, busy_w;
    logic [8*16-1:0]   out_data_w;
    logic              in_ready_s, out_valid_s, out_mode_s, busy_s;
    logic [8*12-1:0]   out_data_s;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_in [8];
    bit cur_mode;

    always #5 clk = ~clk;

    loeffler_dct_engine #(.IN_W(IN_W), .OUT_W(16), .COEF_W(16), .FRAC(FRAC)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_mode(out_mode_w),
        .busy(busy_w));

    loeffler_dct_engine #(.IN_W(IN_W), .OUT_W(12), .COEF_W(16), .FRAC(FRAC)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_mode(out_mode_s),
        .busy(busy_s));

    typedef struct packed {
        logic [7:0][15:0] din;
        logic             mode;
        logic [7:0][15:0] exp;
        logic [7:0]       mask;
        logic             chk12;
        logic [15:0]      exp12_0;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint rnd_real(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    endfunction

    function automatic longint coef(input int k, input int n);
        real pi, ck;
        pi = 3.14159265358979323846;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        return rnd_real((2.0 ** FRAC) * ck / 2.0 * $cos((2.0 * n + 1.0) * k * pi / 16.0));
    endfunction

    function automatic longint model(input int idx, input int outw);
        longint s, r, hi, lo;
        s = 0;
        for (int i = 0; i < 8; i++)
            s += longint'(cur_in[i]) * (cur_mode ? coef(i, idx) : coef(idx, i));
        r  = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
        hi = (longint'(1) << (outw - 1)) - 1;
        lo = -(longint'(1) << (outw - 1));
        return (r > hi) ? hi : ((r < lo) ? lo : r);
    endfunction

    function automatic longint gw(input int i);
        return longint'($signed(out_data_w[i*16 +: 16]));
    endfunction

    function automatic longint gs(input int i);
        return longint'($signed(out_data_s[i*12 +: 12]));
    endfunction

    task automatic drive_cur();
        in_mode = cur_mode;
        for (int i = 0; i < 8; i++) in_data[i*IN_W +: IN_W] = cur_in[i][IN_W-1:0];
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic apply(input string tag);
        int w;
        in_valid = 1'b1;
        drive_cur();
        w = 0;
        while (!in_ready_w && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept_ready"}, longint'(in_ready_w), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_mode  = ~cur_mode;
        in_data  = {$urandom, $urandom, $urandom};
    endtask

    task automatic collect(input string tag);
        int lat;
        lat = 0;
        while (!out_valid_w && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " valid12"}, longint'(out_valid_s), 1);
        chk({tag, " mode"}, longint'(out_mode_w), longint'(cur_mode));
        chk({tag, " mode12"}, longint'(out_mode_s), longint'(cur_mode));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s w16[%0d]", tag, i), gw(i), model(i, 16));
            chk($sformatf("%s w12[%0d]", tag, i), gs(i), model(i, 12));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid_after_hs"}, longint'(out_valid_w), 0);
        chk({tag, " ready_after_hs"}, longint'(in_ready_w), 1);
    endtask

    initial begin
        bit   seen;
        logic [8*16-1:0] held;

        for (int t = 0; t < 5; t++) tbl[t] = '0;
        for (int n = 0; n < 8; n++) begin
            tbl[0].din[n] = 16'd100;
            tbl[1].din[n] = 16'(50 + 10 * n);
            tbl[3].din[n] = 16'd2047;
            tbl[4].din[n] = 16'(-2048);
            tbl[2].exp[n] = 16'd100;
        end
        tbl[0].exp[0] = 16'd283;            tbl[0].mask = 8'hFF;
        tbl[1].exp[0] = 16'd240;            tbl[1].exp[1] = 16'(-64);
        tbl[1].mask   = 8'b0101_0111;
        tbl[2].din[0] = 16'd283;            tbl[2].mode = 1'b1;  tbl[2].mask = 8'hFF;
        tbl[3].exp[0] = 16'd5790;           tbl[3].mask = 8'hFF;
        tbl[3].chk12  = 1'b1;               tbl[3].exp12_0 = 16'd2047;
        tbl[4].exp[0] = 16'(-5793);         tbl[4].mask = 8'hFF;
        tbl[4].chk12  = 1'b1;               tbl[4].exp12_0 = 16'(-2048);

        // Reset held with a valid vector pending: nothing may be accepted.
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        for (int n = 0; n < 8; n++) cur_in[n] = 100;
        cur_mode = 1'b0;
        drive_cur();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst in_ready", longint'(in_ready_w), 1);
            chk("rst out_valid", longint'(out_valid_w), 0);
            chk("rst busy", longint'(busy_w), 0);
            chk("rst out_data", longint'(out_data_w != '0), 0);
            chk("rst out_mode", longint'(out_mode_w), 0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst accepted", longint'(busy_w), 1);
        in_valid = 1'b0;
        collect("post_rst");
        release_out("post_rst");

        for (int t = 0; t < 5; t++) begin
            for (int n = 0; n < 8; n++) cur_in[n] = int'($signed(tbl[t].din[n]));
            cur_mode = tbl[t].mode;
            apply($sformatf("tbl%0d", t));
            collect($sformatf("tbl%0d", t));
            for (int n = 0; n < 8; n++)
                if (tbl[t].mask[n])
                    chk($sformatf("tbl%0d const[%0d]", t, n), gw(n), longint'($signed(tbl[t].exp[n])));
            if (tbl[t].chk12)
                chk($sformatf("tbl%0d sat12", t), gs(0), longint'($signed(tbl[t].exp12_0)));
            release_out($sformatf("tbl%0d", t));
        end

        for (int r = 0; r < 24; r++) begin
            for (int n = 0; n < 8; n++) cur_in[n] = int'($urandom_range(0, 4095)) - 2048;
            cur_mode = 1'($urandom_range(0, 1));
            apply($sformatf("rnd%0d", r));
            collect($sformatf("rnd%0d", r));
            release_out($sformatf("rnd%0d", r));
        end

        // Backpressure with a second vector pending, then back-to-back accept.
        for (int n = 0; n < 8; n++) cur_in[n] = 30 * n - 100;
        cur_mode = 1'b0;
        apply("bp_a");
        collect("bp_a");
        held = out_data_w;
        for (int n = 0; n < 8; n++) cur_in[n] = 400 - 90 * n;
        cur_mode = 1'b1;
        in_valid = 1'b1;
        drive_cur();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp stable", longint'(out_data_w == held), 1);
            chk("bp in_ready", longint'(in_ready_w), 0);
            chk("bp out_valid", longint'(out_valid_w), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready", longint'(in_ready_w), 1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b busy", longint'(busy_w), 1);
        chk("b2b out_valid", longint'(out_valid_w), 0);
        collect("bp_b");
        release_out("bp_b");

        // Reset while computing k=4: the vector's result never appears.
        for (int n = 0; n < 8; n++) cur_in[n] = 700;
        cur_mode = 1'b0;
        apply("midrst");
        repeat (4) @(negedge clk);
        chk("midrst busy", longint'(busy_w), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid_w || busy_w) seen = 1'b1;
        end
        chk("midrst no_result", longint'(seen), 0);
        chk("midrst out_data", longint'(out_data_w != '0), 0);
        chk("midrst in_ready", longint'(in_ready_w), 1);

        // Reset wins over a simultaneous handshake + new accept.
        for (int n = 0; n < 8; n++) cur_in[n] = -300 + n;
        cur_mode = 1'b1;
        apply("rst_hs");
        collect("rst_hs");
        out_ready = 1'b1; in_valid = 1'b1; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        chk("rst_hs out_valid", longint'(out_valid_w), 0);
        chk("rst_hs busy", longint'(busy_w), 0);
        chk("rst_hs out_data", longint'(out_data_w != '0), 0);
        chk("rst_hs out_mode", longint'(out_mode_w), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/loeffler_dct_engine.md
Name: loeffler_dct_engine

Overview:
- Parametrised, handshaked 8-point 1-D transform engine for the JPEG decoder.
- Selectable per vector: forward DCT-II or inverse DCT (DCT-III).
- Evaluates one output coefficient per cycle with 8 parallel multipliers and an adder tree. Runs from a fixed-point coefficient ROM.
- Sits between dequantisation and the row/column transpose buffer. Full ready/valid on both sides, with saturation to a parametrised output width.

Parameters:
- IN_W, 12, signed input sample width.
- OUT_W, 16, signed output sample width; results saturate to this range.
- COEF_W, 16, signed coefficient ROM width.
- FRAC, 14, coefficient fractional bits.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept a vector this cycle.
- in_mode  in  1  0 = forward DCT, 1 = inverse DCT; sampled at accept.
- in_data  in  8 x IN_W  signed input vector, element 0..7.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  8 x OUT_W  signed result vector.
- out_mode  out  1  mode the result was computed with.
- busy  out  1  high in COMPUTE state.

Behaviour:
- Reset is synchronous and active-low: rst sampled low at a rising edge clears all state.
- Outputs after reset: state IDLE, in_ready=1, out_valid=0, busy=0, out_data all 0, out_mode=0, k counter 0.
- Coefficients: C[k][n] = round(2^FRAC * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt2 and c(k>0)=1.
  - Constant ROM; with defaults, C[0][*]=5793 and row 1 = 8035,6811,4551,1598,-1598,-4551,-6811,-8035.
- Forward: y[k] = sum_n x[n]*C[k][n]. Inverse: y[n] = sum_k X[k]*C[k][n], i.e. the transposed ROM.
- Arithmetic and width rules:
  - Products are IN_W+COEF_W bits; the sum is IN_W+COEF_W+3 bits; no intermediate truncation.
  - Scaling: (sum + 2^(FRAC-1)) arithmetic-shift-right FRAC (round half up).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data and in_mode, k=0, go to COMPUTE.
- COMPUTE:
  - in_ready=0, busy=1.
  - Each cycle computes result index k and writes it to the output register; k increments.
  - After k=7, go to DONE.
  - Exactly 8 cycles.
- DONE:
  - out_valid=1; out_data and out_mode stable until handshake.
  - in_ready = out_ready.
  - On out_valid&&out_ready with in_valid: accept the new vector the same cycle and go to COMPUTE (back-to-back).
  - On out_valid&&out_ready without in_valid: go to IDLE.
  - Without out_ready: hold indefinitely (backpressure); no input accepted.
- Latency: accept at edge T gives out_valid=1 after edge T+8 (9th cycle). Peak throughput is one vector per 9 cycles.
- out_data keeps its last value after handshake; only out_valid qualifies it.
- in_mode and in_data changes while not accepting are ignored; the latched copy is used for the whole computation.
- Reset mid-COMPUTE or during DONE: abort, return to reset values; the partial result is never presented.
- A simultaneous reset and handshake loses to reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, no accept; release -> accept on the next edge.
- Forward DC, defaults: in_data all 100, mode 0 -> out_valid exactly 9 cycles after accept; out_data[0]=283, out_data[1..7]=0.
- Forward ramp: 50,60,70,80,90,100,110,120, mode 0 -> out[0]=240, out[1]=-64, out[2]=out[4]=out[6]=0.
- Inverse round trip: in_data {283,0,...,0}, mode 1 -> all eight outputs =100, out_mode=1.
- Saturation with OUT_W=12: all inputs 2047, mode 0 -> out[0]=2047 (true value 5790), others 0. All inputs -2048 -> out[0]=-2048.
- Backpressure/back-to-back and mid-op reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0.
  - Raise out_ready with a second vector valid -> the second vector is accepted the same edge, its result 9 cycles later.
  - Reset asserted at k=4 -> out_valid never rises for that vector.
